// File: rtl/otp_ctrl_pkg.sv
// Shared level codes, mode codes and state encoding for the OTP array controller.
package otp_ctrl_pkg;

    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;
    localparam logic [1:0] MODE_IDLE  = 2'b10;

    localparam logic [1:0] PL_GND  = 2'b00;
    localparam logic [1:0] PL_MID  = 2'b01;
    localparam logic [1:0] PL_READ = 2'b10;
    localparam logic [1:0] PL_HIGH = 2'b11;

    localparam logic BL_GND   = 1'b0;
    localparam logic BL_MID   = 1'b1;
    localparam logic WLN_MID  = 1'b0;
    localparam logic WLN_GND  = 1'b1;
    localparam logic WLP_HIGH = 1'b0;
    localparam logic WLP_MID  = 1'b1;

    localparam logic PRG_WRITE = 1'b1;
    localparam logic PRG_READ  = 1'b0;
    localparam logic READ_ON   = 1'b1;
    localparam logic READ_OFF  = 1'b0;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_W_PULSE = 2'd1;
    localparam state_t ST_W_CHECK = 2'd2;
    localparam state_t ST_R_ROW   = 2'd3;

endpackage

// File: rtl/otp_bias_decoder.sv
// Moore decode of array driver levels from state, biased row and latched column.
module otp_bias_decoder
    import otp_ctrl_pkg::*;
#(
    parameter int A  = 2,
    parameter int B  = 2,
    parameter int RW = 1,
    parameter int AW = 1
) (
    input  state_t            state,
    input  logic [RW-1:0]     row,
    input  logic [AW-1:0]     col,
    output logic [2*B-1:0]    pl,
    output logic [B-1:0]      bl,
    output logic [A-1:0]      wln,
    output logic [A-1:0]      wlp,
    output logic              prg
);

    always_comb begin
        pl  = {B{PL_GND}};
        bl  = {B{BL_GND}};
        wln = {A{WLN_GND}};
        wlp = {A{WLP_MID}};
        prg = PRG_READ;
        case (state)
            ST_W_PULSE: begin
                // unselected columns sit at the inhibit level while one cell is pulsed
                prg             = PRG_WRITE;
                pl              = {B{PL_MID}};
                bl              = {B{BL_MID}};
                pl[2*col +: 2]  = PL_HIGH;
                bl[col]         = BL_GND;
                wln[row]        = WLN_MID;
                wlp[row]        = WLP_HIGH;
            end
            ST_W_CHECK, ST_R_ROW: begin
                pl[2*col +: 2]  = PL_READ;
                bl[col]         = BL_MID;
                wln[row]        = WLN_MID;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/otp_ctrl_fsm.sv
// OTP array sequencer: row-by-row program/verify with retry, and row-by-row read.
//   state      | meaning
//   ST_IDLE    | idle bias, sample mode
//   ST_W_PULSE | program pulse on [row][col], PULSE_CYCLES long
//   ST_W_CHECK | verify cycle under read bias
//   ST_R_ROW   | read bias on [row][col], READ_CYCLES long
module otp_ctrl_fsm
    import otp_ctrl_pkg::*;
#(
    parameter int A            = 2,
    parameter int B            = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int READ_CYCLES  = 2,
    parameter int MAX_RETRIES  = 3,
    localparam int ADDR_WIDTH  = $clog2(B)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] column,
    input  logic [A-1:0]          data_in,
    input  logic                  writing_successful,
    input  logic                  output_read_circuit,
    output logic [2*B-1:0]        PL,
    output logic [B-1:0]          BL,
    output logic [A-1:0]          WLN,
    output logic [A-1:0]          WLP,
    output logic                  PRG,
    output logic                  read_active,
    output logic [A-1:0]          data_out
);

    localparam int RW = (A > 1) ? $clog2(A) : 1;
    localparam int CW = $clog2(((PULSE_CYCLES > READ_CYCLES) ? PULSE_CYCLES : READ_CYCLES) + 1);
    localparam int TW = $clog2(MAX_RETRIES + 1) + 1;
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] READ_LOAD  = CW'(READ_CYCLES - 1);

    state_t                  state;
    logic [RW-1:0]           row;
    logic [TW-1:0]           retry;
    logic [CW-1:0]           cnt;
    logic [ADDR_WIDTH-1:0]   col_q;
    logic [A-1:0]            data_q;
    logic                    col_ok;
    logic                    first_found, next_found;
    logic [RW-1:0]           first_row, next_row;

    assign col_ok = (int'(column) < B);

    // Row skip: lowest row still to program, searched downward so the lowest hit wins.
    always_comb begin
        first_found = 1'b0;
        first_row   = '0;
        next_found  = 1'b0;
        next_row    = '0;
        for (int i = A - 1; i >= 0; i--) begin
            if (data_in[i]) begin
                first_found = 1'b1;
                first_row   = RW'(i);
            end
            if (data_q[i] && (i > int'(row))) begin
                next_found = 1'b1;
                next_row   = RW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            row      <= '0;
            retry    <= '0;
            cnt      <= '0;
            col_q    <= '0;
            data_q   <= '0;
            data_out <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mode == MODE_WRITE && col_ok) begin
                        col_q  <= column;
                        data_q <= data_in;
                        retry  <= '0;
                        cnt    <= PULSE_LOAD;
                        if (first_found) begin
                            row   <= first_row;
                            state <= ST_W_PULSE;
                        end
                    end else if (mode == MODE_READ && col_ok) begin
                        col_q    <= column;
                        data_out <= '0;
                        row      <= '0;
                        cnt      <= READ_LOAD;
                        state    <= ST_R_ROW;
                    end
                end
                ST_W_PULSE: begin
                    if (cnt == '0) state <= ST_W_CHECK;
                    else           cnt   <= cnt - CW'(1);
                end
                ST_W_CHECK: begin
                    cnt <= PULSE_LOAD;
                    if (writing_successful || retry == TW'(MAX_RETRIES)) begin
                        retry <= '0;
                        if (next_found) begin
                            row   <= next_row;
                            state <= ST_W_PULSE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        retry <= retry + TW'(1);
                        state <= ST_W_PULSE;
                    end
                end
                ST_R_ROW: begin
                    if (cnt == '0) begin
                        data_out[row] <= output_read_circuit;
                        cnt           <= READ_LOAD;
                        if (row == RW'(A - 1)) state <= ST_IDLE;
                        else                   row   <= row + RW'(1);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign read_active = (state == ST_R_ROW) ? READ_ON : READ_OFF;

    otp_bias_decoder #(.A(A), .B(B), .RW(RW), .AW(ADDR_WIDTH)) u_bias (
        .state (state),
        .row   (row),
        .col   (col_q),
        .pl    (PL),
        .bl    (BL),
        .wln   (WLN),
        .wlp   (WLP),
        .prg   (PRG)
    );

endmodule

// File: tb/tb_otp_ctrl_fsm.sv
// Scoreboard bench for otp_ctrl_fsm: per-cycle expected outputs queued by stimulus, popped by a monitor.
module tb_otp_ctrl_fsm;

    localparam int A  = 2;
    localparam int B  = 2;
    localparam int PC = 4;
    localparam int RC = 2;
    localparam int MR = 3;
    localparam int AW = $clog2(B);

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic [AW-1:0] column;
    logic [A-1:0]  data_in;
    logic          ws;
    logic          orc;
    logic [2*B-1:0] PL;
    logic [B-1:0]  BL;
    logic [A-1:0]  WLN, WLP;
    logic          PRG;
    logic          read_active;
    logic [A-1:0]  data_out;

    always #5 clk = ~clk;

    otp_ctrl_fsm dut (
        .clk                 (clk),
        .reset               (reset),
        .mode                (mode),
        .column              (column),
        .data_in             (data_in),
        .writing_successful  (ws),
        .output_read_circuit (orc),
        .PL                  (PL),
        .BL                  (BL),
        .WLN                 (WLN),
        .WLP                 (WLP),
        .PRG                 (PRG),
        .read_active         (read_active),
        .data_out            (data_out)
    );

    typedef struct packed {
        logic [2*B-1:0] pl;
        logic [B-1:0]   bl;
        logic [A-1:0]   wln;
        logic [A-1:0]   wlp;
        logic           prg;
        logic           ra;
        logic [A-1:0]   dout;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         sq[$];
    logic         wq[$];
    logic         oq[$];
    int           checks = 0;
    int           errors = 0;
    logic [A-1:0] dout_m = '0;
    int           fail_cnt[A];

    // kind: 0 idle, 1 program pulse, 2 read/verify bias
    function automatic exp_t bias(input int kind, input int r, input int c, input logic ra,
                                  input logic [A-1:0] d);
        exp_t e;
        e.pl = '0; e.bl = '0; e.wln = '1; e.wlp = '1; e.prg = 1'b0; e.ra = ra; e.dout = d;
        if (kind == 1) begin
            e.prg = 1'b1;
            for (int j = 0; j < B; j++) begin
                e.pl[2*j +: 2] = (j == c) ? 2'b11 : 2'b01;
                e.bl[j]        = (j == c) ? 1'b0 : 1'b1;
            end
            e.wlp[r] = 1'b0;
            e.wln[r] = 1'b0;
        end else if (kind == 2) begin
            e.pl[2*c +: 2] = 2'b10;
            e.bl[c]        = 1'b1;
            e.wln[r]       = 1'b0;
        end
        return e;
    endfunction

    function automatic exp_t idle_e();
        return bias(0, 0, 0, 1'b0, dout_m);
    endfunction

    task automatic check_idle(input string tag);
        exp_t e, act;
        @(posedge clk);
        #3;
        e   = idle_e();
        act = {PL, BL, WLN, WLP, PRG, read_active, data_out};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s t=%0t got pl=%b bl=%b wln=%b wlp=%b prg=%b ra=%b dout=%b want dout=%b",
                     tag, $time, act.pl, act.bl, act.wln, act.wlp, act.prg, act.ra, act.dout, e.dout);
        end
    endtask

    initial begin : monitor
        exp_t e, act;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {PL, BL, WLN, WLP, PRG, read_active, data_out};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got pl=%b bl=%b wln=%b wlp=%b prg=%b ra=%b dout=%b want pl=%b bl=%b wln=%b wlp=%b prg=%b ra=%b dout=%b",
                             $time, act.pl, act.bl, act.wln, act.wlp, act.prg, act.ra, act.dout,
                             e.pl, e.bl, e.wln, e.wlp, e.prg, e.ra, e.dout);
                end
            end
        end
    end

    task automatic step(input logic [1:0] m, input logic [AW-1:0] c, input logic [A-1:0] d,
                        input logic w, input logic o, input logic rst, input exp_t e);
        @(negedge clk);
        mode    = m;
        column  = c;
        data_in = d;
        ws      = w;
        orc     = o;
        reset   = rst;
        exp_q.push_back(e);
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++)
            step(2'b10 | 2'($urandom_range(0, 1)), AW'($urandom), A'($urandom),
                 1'($urandom), 1'($urandom), 1'b0, idle_e());
    endtask

    // Inputs driven on step m are sampled at the end of snapshot m-1; mode is ignored while busy.
    task automatic run_seq(input logic [1:0] start, input logic [AW-1:0] c, input logic [A-1:0] d,
                           input int abort);
        int n;
        n = sq.size();
        step(start, c, d, 1'($urandom), 1'($urandom), 1'b0, (n > 0) ? sq[0] : idle_e());
        for (int m = 1; m <= n; m++) begin
            if (m == abort) begin
                dout_m = '0;
                step(2'($urandom), AW'($urandom), A'($urandom), 1'($urandom), 1'($urandom),
                     1'b1, idle_e());
                return;
            end
            step(2'($urandom), AW'($urandom), A'($urandom), wq[m-1], oq[m-1], 1'b0,
                 (m < n) ? sq[m] : idle_e());
        end
    endtask

    task automatic snap(input exp_t e, input logic w, input logic o);
        sq.push_back(e);
        wq.push_back(w);
        oq.push_back(o);
    endtask

    task automatic do_write(input logic [AW-1:0] c, input logic [A-1:0] d, input int abort);
        int pulses;
        sq.delete(); wq.delete(); oq.delete();
        if (int'(c) < B) begin
            for (int i = 0; i < A; i++) begin
                if (d[i]) begin
                    pulses = ((fail_cnt[i] < MR) ? fail_cnt[i] : MR) + 1;
                    for (int k = 0; k < pulses; k++) begin
                        for (int t = 0; t < PC; t++)
                            snap(bias(1, i, int'(c), 1'b0, dout_m), 1'($urandom), 1'($urandom));
                        snap(bias(2, i, int'(c), 1'b0, dout_m), (k >= fail_cnt[i]), 1'($urandom));
                    end
                end
            end
        end
        run_seq(2'b01, c, d, abort);
    endtask

    task automatic do_read(input logic [AW-1:0] c, input logic [A-1:0] bits, input int abort);
        logic [A-1:0] d;
        d = '0;
        sq.delete(); wq.delete(); oq.delete();
        if (int'(c) < B) begin
            for (int r = 0; r < A; r++) begin
                for (int t = 0; t < RC; t++)
                    snap(bias(2, r, int'(c), 1'b1, d), 1'($urandom),
                         (t == RC - 1) ? bits[r] : 1'($urandom));
                d[r] = bits[r];
            end
            dout_m = d;
        end
        run_seq(2'b00, c, A'($urandom), abort);
    endtask

    initial begin : stim
        int abort;
        reset = 1'b1; mode = 2'b10; column = '0; data_in = '0; ws = 1'b0; orc = 1'b0;
        step(2'b10, '0, '0, 1'b0, 1'b0, 1'b1, idle_e());
        check_idle("reset_state");
        idle_steps(3);

        // two-row write, both verify first time
        fail_cnt[0] = 0; fail_cnt[1] = 0;
        do_write(AW'(0), 2'b11, -1);
        idle_steps(2);
        // only row 1 on column 1
        do_write(AW'(1), 2'b10, -1);
        idle_steps(1);
        // verify never succeeds: 1 + MR pulses then give up
        fail_cnt[0] = 99;
        do_write(AW'(1), 2'b01, -1);
        idle_steps(1);
        // read column 1: row0=1, row1=0
        do_read(AW'(1), 2'b01, -1);
        idle_steps(2);
        // reset landing inside the first program pulse
        fail_cnt[0] = 0; fail_cnt[1] = 0;
        do_write(AW'(0), 2'b11, 2);
        idle_steps(2);
        // nothing to program
        do_write(AW'(1), 2'b00, -1);
        idle_steps(1);

        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < A; i++) fail_cnt[i] = $urandom_range(0, 5);
            abort = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : -1;
            if ($urandom_range(0, 1) == 1)
                do_write(AW'($urandom_range(0, B - 1)), A'($urandom), abort);
            else
                do_read(AW'($urandom_range(0, B - 1)), A'($urandom), abort);
            idle_steps($urandom_range(0, 2));
        end

        idle_steps(2);
        check_idle("expired_wait");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
